angle_term_dispatcher: RTL and testbench

ANGLE_TERM_DISPATCHER -- requirements
Module: angle_term_dispatcher

---
 rtl/angle_term_dispatcher_pkg.sv | 29 ++
 rtl/angle_term_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_angle_term_dispatcher.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/angle_term_dispatcher_pkg.sv
// rtl/angle_term_dispatcher_pkg.sv - shared types and constants for the angle-term dispatcher
package angle_term_dispatcher_pkg;

  // Fixed-point operand width (Q16.16)
  localparam int Q_W = 32;

  // Default index widths and core wait budget
  localparam int ATOM_AW_DEF  = 8;
  localparam int TERM_AW_DEF  = 8;
  localparam int CORE_TMO_DEF = 1023;

  // Cycles allowed for the core to acknowledge core_start
  localparam int LAUNCH_TMO = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_TERM,
    ST_LATCH_TERM,
    ST_RD_CRD,
    ST_LAUNCH,
    ST_WAIT_CORE,
    ST_EMIT_A,
    ST_EMIT_B,
    ST_EMIT_C,
    ST_NEXT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/angle_term_dispatcher.sv
// rtl/angle_term_dispatcher.sv - walks the angle-term table, feeds the angle core, streams forces out
module angle_term_dispatcher
  import angle_term_dispatcher_pkg::*;
#(
  parameter int ATOM_AW  = ATOM_AW_DEF,
  parameter int TERM_AW  = TERM_AW_DEF,
  parameter int CORE_TMO = CORE_TMO_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [TERM_AW:0]   num_terms,
  output logic [TERM_AW-1:0] term_raddr,
  input  logic [ATOM_AW-1:0] term_a,
  input  logic [ATOM_AW-1:0] term_b,
  input  logic [ATOM_AW-1:0] term_c,
  input  logic [Q_W-1:0]     term_theta0,
  input  logic [Q_W-1:0]     term_k,
  output logic [ATOM_AW-1:0] crd_raddr,
  input  logic [Q_W-1:0]     crd_x,
  input  logic [Q_W-1:0]     crd_y,
  input  logic [Q_W-1:0]     crd_z,
  output logic               core_start,
  input  logic               core_busy,
  input  logic               core_valid,
  output logic [Q_W-1:0]     core_xa,
  output logic [Q_W-1:0]     core_ya,
  output logic [Q_W-1:0]     core_za,
  output logic [Q_W-1:0]     core_xb,
  output logic [Q_W-1:0]     core_yb,
  output logic [Q_W-1:0]     core_zb,
  output logic [Q_W-1:0]     core_xc,
  output logic [Q_W-1:0]     core_yc,
  output logic [Q_W-1:0]     core_zc,
  output logic [Q_W-1:0]     core_theta0,
  output logic [Q_W-1:0]     core_k,
  input  logic [Q_W-1:0]     core_fax,
  input  logic [Q_W-1:0]     core_fay,
  input  logic [Q_W-1:0]     core_faz,
  input  logic [Q_W-1:0]     core_fbx,
  input  logic [Q_W-1:0]     core_fby,
  input  logic [Q_W-1:0]     core_fbz,
  input  logic [Q_W-1:0]     core_fcx,
  input  logic [Q_W-1:0]     core_fcy,
  input  logic [Q_W-1:0]     core_fcz,
  output logic               fw_valid,
  input  logic               fw_ready,
  output logic [ATOM_AW-1:0] fw_atom,
  output logic [Q_W-1:0]     fw_fx,
  output logic [Q_W-1:0]     fw_fy,
  output logic [Q_W-1:0]     fw_fz,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [TERM_AW:0]   skipped
);

  state_t             state;
  logic [TERM_AW:0]   idx;
  logic [TERM_AW:0]   num_r;
  logic [ATOM_AW-1:0] atom_a;
  logic [ATOM_AW-1:0] atom_b;
  logic [ATOM_AW-1:0] atom_c;
  logic [1:0]         crd_step;
  logic [15:0]        tmo;

  // Forces for B and C wait here while A is being streamed out
  logic [Q_W-1:0]     f_bx, f_by, f_bz;
  logic [Q_W-1:0]     f_cx, f_cy, f_cz;

  logic [TERM_AW:0]   idx_inc;
  logic               last_term;
  logic               degenerate;

  assign idx_inc    = idx + 1'b1;
  assign last_term  = (idx == num_r - 1'b1);
  // A term sharing an atom between any two positions has no defined angle
  assign degenerate = (term_a == term_b) || (term_b == term_c) || (term_a == term_c);

  // Term sequencer: table walk, coordinate fetch, core handshake and force streaming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      num_r       <= '0;
      atom_a      <= '0;
      atom_b      <= '0;
      atom_c      <= '0;
      crd_step    <= '0;
      tmo         <= '0;
      term_raddr  <= '0;
      crd_raddr   <= '0;
      core_start  <= 1'b0;
      core_xa     <= '0;
      core_ya     <= '0;
      core_za     <= '0;
      core_xb     <= '0;
      core_yb     <= '0;
      core_zb     <= '0;
      core_xc     <= '0;
      core_yc     <= '0;
      core_zc     <= '0;
      core_theta0 <= '0;
      core_k      <= '0;
      f_bx        <= '0;
      f_by        <= '0;
      f_bz        <= '0;
      f_cx        <= '0;
      f_cy        <= '0;
      f_cz        <= '0;
      fw_valid    <= 1'b0;
      fw_atom     <= '0;
      fw_fx       <= '0;
      fw_fy       <= '0;
      fw_fz       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      skipped     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            idx        <= '0;
            skipped    <= '0;
            err        <= 1'b0;
            num_r      <= num_terms;
            term_raddr <= '0;
            if (num_terms == '0) begin
              // Nothing to do: go straight to the done pulse, busy never rises
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              busy  <= 1'b1;
              state <= ST_RD_TERM;
            end
          end
        end

        ST_RD_TERM: begin
          // term_raddr already holds idx; table data appears next cycle
          state <= ST_LATCH_TERM;
        end

        ST_LATCH_TERM: begin
          atom_a      <= term_a;
          atom_b      <= term_b;
          atom_c      <= term_c;
          core_theta0 <= term_theta0;
          core_k      <= term_k;
          if (degenerate) begin
            skipped <= skipped + 1'b1;
            state   <= ST_NEXT;
          end else begin
            crd_raddr <= term_a;
            crd_step  <= '0;
            state     <= ST_RD_CRD;
          end
        end

        ST_RD_CRD: begin
          // Address leads data by one cycle: A,B,C issued on steps 0-2, captured on 1-3
          crd_step <= crd_step + 1'b1;
          case (crd_step)
            2'd0: begin
              crd_raddr <= atom_b;
            end
            2'd1: begin
              crd_raddr <= atom_c;
              core_xa   <= crd_x;
              core_ya   <= crd_y;
              core_za   <= crd_z;
            end
            2'd2: begin
              core_xb <= crd_x;
              core_yb <= crd_y;
              core_zb <= crd_z;
            end
            default: begin
              core_xc    <= crd_x;
              core_yc    <= crd_y;
              core_zc    <= crd_z;
              core_start <= 1'b1;
              tmo        <= '0;
              state      <= ST_LAUNCH;
            end
          endcase
        end

        ST_LAUNCH: begin
          if (core_busy) begin
            core_start <= 1'b0;
            tmo        <= '0;
            state      <= ST_WAIT_CORE;
          end else if (tmo == 16'(LAUNCH_TMO - 1)) begin
            core_start <= 1'b0;
            err        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_FINISH;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        ST_WAIT_CORE: begin
          if (core_valid) begin
            // A's force goes straight onto the stream; B and C are parked
            fw_valid <= 1'b1;
            fw_atom  <= atom_a;
            fw_fx    <= core_fax;
            fw_fy    <= core_fay;
            fw_fz    <= core_faz;
            f_bx     <= core_fbx;
            f_by     <= core_fby;
            f_bz     <= core_fbz;
            f_cx     <= core_fcx;
            f_cy     <= core_fcy;
            f_cz     <= core_fcz;
            state    <= ST_EMIT_A;
          end else if (tmo == 16'(CORE_TMO - 1)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        ST_EMIT_A: begin
          if (fw_ready) begin
            fw_atom <= atom_b;
            fw_fx   <= f_bx;
            fw_fy   <= f_by;
            fw_fz   <= f_bz;
            state   <= ST_EMIT_B;
          end
        end

        ST_EMIT_B: begin
          if (fw_ready) begin
            fw_atom <= atom_c;
            fw_fx   <= f_cx;
            fw_fy   <= f_cy;
            fw_fz   <= f_cz;
            state   <= ST_EMIT_C;
          end
        end

        ST_EMIT_C: begin
          if (fw_ready) begin
            fw_valid <= 1'b0;
            state    <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          if (last_term) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            idx        <= idx_inc;
            term_raddr <= idx_inc[TERM_AW-1:0];
            state      <= ST_RD_TERM;
          end
        end

        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_angle_term_dispatcher.sv
// tb/tb_angle_term_dispatcher.sv - scoreboard bench for angle_term_dispatcher
module tb_angle_term_dispatcher;

  localparam int AW = 8;
  localparam int TW = 8;

  typedef struct packed {
    logic [AW-1:0] atom;
    logic [31:0]   fx;
    logic [31:0]   fy;
    logic [31:0]   fz;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic [TW:0]   num_terms = '0;
  logic [TW-1:0] term_raddr;
  logic [AW-1:0] term_a, term_b, term_c;
  logic [31:0]   term_theta0, term_k;
  logic [AW-1:0] crd_raddr;
  logic [31:0]   crd_x, crd_y, crd_z;
  logic          core_start, core_busy, core_valid;
  logic [31:0]   core_xa, core_ya, core_za, core_xb, core_yb, core_zb, core_xc, core_yc, core_zc;
  logic [31:0]   core_theta0, core_k;
  logic [31:0]   core_fax, core_fay, core_faz, core_fbx, core_fby, core_fbz, core_fcx, core_fcy, core_fcz;
  logic          fw_valid, fw_ready;
  logic [AW-1:0] fw_atom;
  logic [31:0]   fw_fx, fw_fy, fw_fz;
  logic          busy, done, err;
  logic [TW:0]   skipped;

  angle_term_dispatcher #(.ATOM_AW(AW), .TERM_AW(TW), .CORE_TMO(1023)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .num_terms(num_terms),
    .term_raddr(term_raddr), .term_a(term_a), .term_b(term_b), .term_c(term_c),
    .term_theta0(term_theta0), .term_k(term_k),
    .crd_raddr(crd_raddr), .crd_x(crd_x), .crd_y(crd_y), .crd_z(crd_z),
    .core_start(core_start), .core_busy(core_busy), .core_valid(core_valid),
    .core_xa(core_xa), .core_ya(core_ya), .core_za(core_za),
    .core_xb(core_xb), .core_yb(core_yb), .core_zb(core_zb),
    .core_xc(core_xc), .core_yc(core_yc), .core_zc(core_zc),
    .core_theta0(core_theta0), .core_k(core_k),
    .core_fax(core_fax), .core_fay(core_fay), .core_faz(core_faz),
    .core_fbx(core_fbx), .core_fby(core_fby), .core_fbz(core_fbz),
    .core_fcx(core_fcx), .core_fcy(core_fcy), .core_fcz(core_fcz),
    .fw_valid(fw_valid), .fw_ready(fw_ready), .fw_atom(fw_atom),
    .fw_fx(fw_fx), .fw_fy(fw_fy), .fw_fz(fw_fz),
    .busy(busy), .done(done), .err(err), .skipped(skipped)
  );

  always #5 clk = ~clk;

  // Table and coordinate memories
  logic [AW-1:0] a_t [256];
  logic [AW-1:0] b_t [256];
  logic [AW-1:0] c_t [256];
  logic [31:0]   th_t [256];
  logic [31:0]   k_t [256];
  logic [31:0]   x_m [256];
  logic [31:0]   y_m [256];
  logic [31:0]   z_m [256];

  // Synchronous read memories: data one cycle after address
  always @(posedge clk) begin
    term_a      <= a_t[term_raddr];
    term_b      <= b_t[term_raddr];
    term_c      <= c_t[term_raddr];
    term_theta0 <= th_t[term_raddr];
    term_k      <= k_t[term_raddr];
    crd_x       <= x_m[crd_raddr];
    crd_y       <= y_m[crd_raddr];
    crd_z       <= z_m[crd_raddr];
  end

  int    n_checks = 0;
  int    n_fail = 0;
  xfer_t exp_q[$];
  int    launches = 0;
  int    stall_cycles = 0;
  int    spur_req = 0;
  int    spur_done = 0;
  bit    core_hang = 1'b0;
  bit    rand_ready = 1'b0;
  int    stall_left = 0;
  logic [AW-1:0] stall_atom = '1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Angle-core model: acknowledges, then returns forces derived from its operands
  initial begin
    logic [31:0] fa [3];
    logic [31:0] fb [3];
    logic [31:0] fc [3];
    core_busy = 1'b0;
    core_valid = 1'b0;
    {core_fax, core_fay, core_faz, core_fbx, core_fby, core_fbz, core_fcx, core_fcy, core_fcz} = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        core_busy = 1'b0;
        core_valid = 1'b0;
      end else if (spur_req != spur_done) begin
        {core_fax, core_fay, core_faz, core_fbx, core_fby, core_fbz, core_fcx, core_fcy, core_fcz} = {9{32'hDEAD_BEEF}};
        core_valid = 1'b1;
        @(posedge clk); #1;
        core_valid = 1'b0;
        spur_done++;
      end else if (core_start && !core_busy) begin
        launches++;
        fa[0] = core_xa ^ core_theta0; fa[1] = core_ya ^ core_theta0; fa[2] = core_za ^ core_theta0;
        fb[0] = core_xb + core_k;      fb[1] = core_yb + core_k;      fb[2] = core_zb + core_k;
        fc[0] = core_xc - core_xa;     fc[1] = core_yc - core_ya;     fc[2] = core_zc - core_za;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        core_busy = 1'b1;
        if (core_hang) begin
          while (busy && rst_n) begin @(posedge clk); #1; end
        end else begin
          repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
          {core_fax, core_fay, core_faz} = {fa[0], fa[1], fa[2]};
          {core_fbx, core_fby, core_fbz} = {fb[0], fb[1], fb[2]};
          {core_fcx, core_fcy, core_fcz} = {fc[0], fc[1], fc[2]};
          core_valid = 1'b1;
          @(posedge clk); #1;
          core_valid = 1'b0;
        end
        core_busy = 1'b0;
      end
    end
  end

  // Downstream ready driver
  initial begin
    fw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && fw_valid && fw_atom == stall_atom) begin
        fw_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        fw_ready = ($urandom_range(0, 3) != 0);
      end else begin
        fw_ready = 1'b1;
      end
    end
  end

  // Stream monitor: pops the scoreboard on each transfer and checks hold-while-stalled
  initial begin
    bit    pend = 1'b0;
    xfer_t held;
    xfer_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (fw_valid) check("fw_hold", {fw_atom, fw_fx, fw_fy, fw_fz}, held);
          else          check("fw_drop", fw_valid, 1'b1);
        end
        if (fw_valid && !fw_ready) begin
          pend = 1'b1;
          held = {fw_atom, fw_fx, fw_fy, fw_fz};
          stall_cycles++;
        end else begin
          pend = 1'b0;
        end
        if (fw_valid && fw_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL fw_unexpected: got atom %0h fx %0h expected no transfer", fw_atom, fw_fx);
          end else begin
            e = exp_q.pop_front();
            check("fw_xfer", {fw_atom, fw_fx, fw_fy, fw_fz}, e);
          end
        end
      end
    end
  end

  function automatic bit distinct(input int t);
    return (a_t[t] != b_t[t]) && (b_t[t] != c_t[t]) && (a_t[t] != c_t[t]);
  endfunction

  // Reference: each well-formed term yields A,B,C forces from the core's rule
  task automatic push_term(input int t);
    xfer_t x;
    logic [AW-1:0] a, b, c;
    a = a_t[t]; b = b_t[t]; c = c_t[t];
    x = {a, x_m[a] ^ th_t[t], y_m[a] ^ th_t[t], z_m[a] ^ th_t[t]};
    exp_q.push_back(x);
    x = {b, x_m[b] + k_t[t], y_m[b] + k_t[t], z_m[b] + k_t[t]};
    exp_q.push_back(x);
    x = {c, x_m[c] - x_m[a], y_m[c] - y_m[a], z_m[c] - z_m[a]};
    exp_q.push_back(x);
  endtask

  task automatic run_job(input int n, input bit use_model, input bit extra_go, input string tag);
    int skip_exp = 0;
    int launch_exp = 0;
    int cnt = 0;
    int l0;
    for (int t = 0; t < n; t++) begin
      if (distinct(t)) begin
        launch_exp++;
        if (use_model) push_term(t);
      end else begin
        skip_exp++;
      end
    end
    l0 = launches;
    @(negedge clk);
    num_terms = (TW+1)'(n);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    while (!done && cnt < 20000) begin
      @(negedge clk);
      cnt++;
      go = extra_go && (cnt == 10);
      if (go) num_terms = '0;
    end
    go = 1'b0;
    check({tag, " done"}, done, 1'b1);
    check({tag, " skipped"}, skipped, (TW+1)'(skip_exp));
    check({tag, " err"}, err, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " launches"}, launches - l0, launch_exp);
    check({tag, " left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 1'b0);
  endtask

  task automatic set_term(input int t, input int a, input int b, input int c, input logic [31:0] th, input logic [31:0] k);
    a_t[t] = AW'(a); b_t[t] = AW'(b); c_t[t] = AW'(c); th_t[t] = th; k_t[t] = k;
  endtask

  task automatic wait_core_wait(output int ok);
    int cnt = 0;
    while (!(core_busy && !core_start && busy) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    ok = (cnt < 500);
  endtask

  initial begin
    int l0, s0, n, ok;
    for (int i = 0; i < 256; i++) begin
      x_m[i] = $urandom; y_m[i] = $urandom; z_m[i] = $urandom;
      set_term(i, 0, 0, 0, 32'h0, 32'h0);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy/done/err", {busy, done, err}, 3'b000);
    check("rst core_start/fw_valid", {core_start, fw_valid}, 2'b00);
    check("rst addr", {term_raddr, crd_raddr, skipped}, '0);
    check("rst operands", {core_xa, core_zc, core_theta0, core_k, fw_fx}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty job
    l0 = launches;
    num_terms = '0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("zero done", done, 1'b1);
    check("zero err/busy", {err, busy}, 2'b00);
    @(negedge clk);
    check("zero done_pulse", done, 1'b0);
    check("zero launches", launches - l0, 0);

    // Single term with fixed forces
    set_term(0, 0, 1, 2, 32'h0, 32'h0);
    x_m[0] = 32'h0001_0000; x_m[1] = 32'hFFFE_0000; x_m[2] = 32'h0002_0000;
    for (int i = 0; i < 3; i++) begin y_m[i] = '0; z_m[i] = '0; end
    exp_q.push_back({8'd0, 32'h0001_0000, 32'h0, 32'h0});
    exp_q.push_back({8'd1, 32'hFFFE_0000, 32'h0, 32'h0});
    exp_q.push_back({8'd2, 32'h0001_0000, 32'h0, 32'h0});
    run_job(1, 1'b0, 1'b0, "single");

    // Stray core_valid while idle, then three terms with a degenerate middle one
    spur_req++;
    repeat (4) @(negedge clk);
    set_term(0, 1, 2, 3, $urandom, $urandom);
    set_term(1, 5, 5, 7, $urandom, $urandom);
    set_term(2, 4, 8, 9, $urandom, $urandom);
    run_job(3, 1'b1, 1'b1, "three");

    // Backpressure on the B transfer
    set_term(0, 0, 1, 2, $urandom, $urandom);
    stall_atom = 8'd1;
    stall_left = 7;
    s0 = stall_cycles;
    run_job(1, 1'b1, 1'b0, "stall");
    check("stall cycles", stall_cycles - s0, 7);
    stall_atom = '1;

    // Random jobs with random backpressure
    rand_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 6);
      for (int t = 0; t < n; t++)
        set_term(t, $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11), $urandom, $urandom);
      run_job(n, 1'b1, 1'b0, "random");
    end
    rand_ready = 1'b0;

    // Core never answers
    core_hang = 1'b1;
    set_term(0, 3, 4, 6, 32'h0, 32'h0);
    @(negedge clk);
    num_terms = 1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_core_wait(ok);
    check("hang reached wait", ok, 1);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      go = (n == 100);
      num_terms = '0;
    end
    go = 1'b0;
    check("hang wait cycles", n, 1023);
    check("hang err/busy", {err, busy}, 2'b10);
    @(negedge clk);
    check("hang err sticky", {err, done}, 2'b10);
    check("hang left", exp_q.size(), 0);

    // Reset while waiting on the core
    set_term(0, 2, 9, 11, $urandom, $urandom);
    x_m[2] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    num_terms = 1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_core_wait(ok);
    check("rstmid reached wait", ok, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid flags", {busy, done, err, core_start, fw_valid}, 5'b0);
    check("rstmid addr", {term_raddr, crd_raddr, skipped}, '0);
    check("rstmid operands", {core_xa, core_theta0, fw_atom, fw_fx}, '0);
    core_hang = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_job(1, 1'b1, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
